// File: rtl/ofs_plat_prim_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_prim_arb_pkg
// Description : Shared sizing helpers for the ready/enable arbiter family.
// Revision    : 1.0
// ============================================================================
package ofs_plat_prim_arb_pkg;

    localparam int DEFAULT_N_SOURCES   = 4;
    localparam int DEFAULT_N_DATA_BITS = 32;

    // Index width that stays at least 1 bit so single-source builds still
    // have a legal vector. Users declare:
    //   typedef logic [idx_width(N_SOURCES)-1:0] t_src_idx;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_prim_ready_enable_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_prim_ready_enable_arb_if
// Description : N source ready/enable channels plus one destination channel.
// Revision    : 1.0
// ============================================================================
interface ofs_plat_prim_ready_enable_arb_if
    import ofs_plat_prim_arb_pkg::*;
#(
    parameter int N_SOURCES   = DEFAULT_N_SOURCES,
    parameter int N_DATA_BITS = DEFAULT_N_DATA_BITS
);
    localparam int IDX_W = idx_width(N_SOURCES);

    logic [N_SOURCES-1:0]   enable_from_src;
    logic [N_DATA_BITS-1:0] data_from_src [N_SOURCES];
    logic [N_SOURCES-1:0]   eop_from_src;
    logic [N_SOURCES-1:0]   ready_to_src;

    logic                   enable_to_dst;
    logic [N_DATA_BITS-1:0] data_to_dst;
    logic                   eop_to_dst;
    logic [IDX_W-1:0]       src_idx_to_dst;
    logic                   ready_from_dst;

    // slave: the arbiter; master: the surrounding sources and destination
    modport slave (
        input  enable_from_src, data_from_src, eop_from_src, ready_from_dst,
        output ready_to_src, enable_to_dst, data_to_dst, eop_to_dst, src_idx_to_dst
    );

    modport master (
        output enable_from_src, data_from_src, eop_from_src, ready_from_dst,
        input  ready_to_src, enable_to_dst, data_to_dst, eop_to_dst, src_idx_to_dst
    );

endinterface
`default_nettype wire

// File: rtl/ofs_plat_prim_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_prim_rr_arb
// Description : Combinational round-robin pick: first request at or above ptr.
// Revision    : 1.0
// ============================================================================
module ofs_plat_prim_rr_arb
    import ofs_plat_prim_arb_pkg::*;
#(
    parameter  int N_SOURCES = DEFAULT_N_SOURCES,
    localparam int IDX_W     = idx_width(N_SOURCES)
)
(
    input  wire logic [N_SOURCES-1:0] req,
    input  wire logic [IDX_W-1:0]     ptr,
    output logic      [N_SOURCES-1:0] grant,
    output logic      [IDX_W-1:0]     grant_idx,
    output logic                      grant_any
);

    always_comb begin
        int pos;
        pos       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N_SOURCES; i++) begin
            // ptr is always < N_SOURCES, so one wrap subtraction suffices
            pos = int'(ptr) + i;
            if (pos >= N_SOURCES) begin
                pos = pos - N_SOURCES;
            end
            if (!grant_any && req[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = IDX_W'(pos);
                grant_any  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofs_plat_prim_ready_enable_arb.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_prim_ready_enable_arb
// Description : Round-robin arbiter feeding one registered ready/enable stage.
//               Define OFS_PLAT_PRIM_ARB_PKT_LOCK_EN to hold grants per packet.
// Revision    : 1.0
// ============================================================================
module ofs_plat_prim_ready_enable_arb
    import ofs_plat_prim_arb_pkg::*;
#(
    parameter int N_SOURCES   = DEFAULT_N_SOURCES,
    parameter int N_DATA_BITS = DEFAULT_N_DATA_BITS
)
(
    input wire logic clk,
    input wire logic reset_n,
    ofs_plat_prim_ready_enable_arb_if.slave bus
);

    typedef logic [idx_width(N_SOURCES)-1:0] t_src_idx;
    localparam t_src_idx LAST_IDX = t_src_idx'(N_SOURCES - 1);

    logic                   r_enable;
    logic [N_DATA_BITS-1:0] r_data;
    logic                   r_eop;
    t_src_idx               r_src_idx;
    t_src_idx               r_rr_ptr;

    logic                   w_out_free;
    logic                   w_xfer;
    logic [N_SOURCES-1:0]   w_req;
    logic [N_SOURCES-1:0]   w_grant;
    t_src_idx               w_grant_idx;
    t_src_idx               w_arb_ptr;
    t_src_idx               w_next_ptr;
    logic                   w_grant_any;
    logic [N_DATA_BITS-1:0] w_sel_data;
    logic                   w_sel_eop;

`ifdef OFS_PLAT_PRIM_ARB_PKT_LOCK_EN
    logic     r_locked;
    t_src_idx r_lock_idx;

    // A locked packet masks every other requester and pins the search start
    always_comb begin
        w_req     = bus.enable_from_src;
        w_arb_ptr = r_rr_ptr;
        if (r_locked) begin
            w_req             = '0;
            w_req[r_lock_idx] = bus.enable_from_src[r_lock_idx];
            w_arb_ptr         = r_lock_idx;
        end
    end
`else
    assign w_req     = bus.enable_from_src;
    assign w_arb_ptr = r_rr_ptr;
`endif

    ofs_plat_prim_rr_arb #(
        .N_SOURCES (N_SOURCES)
    ) u_rr_arb (
        .req       (w_req),
        .ptr       (w_arb_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    assign w_out_free       = !r_enable || bus.ready_from_dst;
    assign w_xfer           = reset_n && w_out_free && w_grant_any;
    assign bus.ready_to_src = (reset_n && w_out_free) ? w_grant : '0;
    assign w_next_ptr       = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + t_src_idx'(1);

    // One-hot AND-OR mux keeps payload off the ready path
    always_comb begin
        w_sel_data = '0;
        w_sel_eop  = 1'b0;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | bus.data_from_src[i];
                w_sel_eop  = w_sel_eop  | bus.eop_from_src[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_enable <= 1'b0;
            r_rr_ptr <= '0;
`ifdef OFS_PLAT_PRIM_ARB_PKT_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else begin
            if (w_out_free) begin
                r_enable <= w_xfer;
            end
            if (w_xfer) begin
`ifdef OFS_PLAT_PRIM_ARB_PKT_LOCK_EN
                r_locked <= !w_sel_eop;
                if (!w_sel_eop) begin
                    r_lock_idx <= w_grant_idx;
                end else begin
                    r_rr_ptr <= w_next_ptr;
                end
`else
                r_rr_ptr <= w_next_ptr;
`endif
            end
        end
    end

    // Payload is qualified by r_enable, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_data    <= w_sel_data;
            r_eop     <= w_sel_eop;
            r_src_idx <= w_grant_idx;
        end
    end

    assign bus.enable_to_dst  = r_enable;
    assign bus.data_to_dst    = r_data;
    assign bus.eop_to_dst     = r_eop;
    assign bus.src_idx_to_dst = r_src_idx;

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_prim_ready_enable_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofs_plat_prim_ready_enable_arb
// Description : Randomized and directed checks against a behavioural model.
// Revision    : 1.0
// ============================================================================
module tb_ofs_plat_prim_ready_enable_arb;
    import ofs_plat_prim_arb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ofs_plat_prim_ready_enable_arb_if #(.N_SOURCES(NS), .N_DATA_BITS(DW)) bus ();
    ofs_plat_prim_ready_enable_arb_if #(.N_SOURCES(1),  .N_DATA_BITS(DW)) bus1 ();

    ofs_plat_prim_ready_enable_arb #(.N_SOURCES(NS), .N_DATA_BITS(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    ofs_plat_prim_ready_enable_arb #(.N_SOURCES(1), .N_DATA_BITS(DW)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int total = 0;
    int bad   = 0;

    // Model: one output slot, a priority pointer and a lock
    bit             m_valid = 1'b0;
    logic [DW-1:0]  m_data  = '0;
    bit             m_eop   = 1'b0;
    int             m_idx   = 0;
    int             m_ptr   = 0;
    bit             m_locked = 1'b0;
    int             m_lock_idx = 0;
    int             last_grant = -1;
    logic [NS-1:0]  dut_ready_last = '0;
    logic [DW-1:0]  acc_q [$];
    int             idx_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!reset_n) return -1;
        if (m_valid && !bus.ready_from_dst) return -1;
`ifdef OFS_PLAT_PRIM_ARB_PKT_LOCK_EN
        if (m_locked) return bus.enable_from_src[m_lock_idx] ? m_lock_idx : -1;
`endif
        for (int k = 0; k < NS; k++) begin
            if (bus.enable_from_src[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
        end
        return -1;
    endfunction

    task automatic check_and_advance();
        int g;
        logic [NS-1:0] exp_ready;
        g = model_grant();
        exp_ready = (g >= 0) ? NS'(1 << g) : '0;
        dut_ready_last = bus.ready_to_src;
        chk("ready_to_src", longint'(bus.ready_to_src), longint'(exp_ready));
        chk("enable_to_dst", longint'(bus.enable_to_dst), longint'(m_valid));
        if (m_valid) begin
            chk("data_to_dst", longint'(bus.data_to_dst), longint'(m_data));
            chk("eop_to_dst", longint'(bus.eop_to_dst), longint'(m_eop));
            chk("src_idx_to_dst", longint'(bus.src_idx_to_dst), longint'(m_idx));
        end
        if (reset_n && bus.enable_to_dst && bus.ready_from_dst) begin
            acc_q.push_back(bus.data_to_dst);
            idx_q.push_back(int'(bus.src_idx_to_dst));
        end
        last_grant = g;
        if (!reset_n) begin
            m_valid = 1'b0; m_ptr = 0; m_locked = 1'b0; m_lock_idx = 0;
        end else begin
            if (!m_valid || bus.ready_from_dst) begin
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_data = bus.data_from_src[g];
                    m_eop  = bus.eop_from_src[g];
                    m_idx  = g;
                end
            end
            if (g >= 0) begin
`ifdef OFS_PLAT_PRIM_ARB_PKT_LOCK_EN
                if (!bus.eop_from_src[g]) begin
                    m_locked = 1'b1; m_lock_idx = g;
                end else begin
                    m_locked = 1'b0; m_ptr = (g + 1) % NS;
                end
`else
                m_ptr = (g + 1) % NS;
`endif
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_src();
        bus.enable_from_src = '0;
        bus.eop_from_src    = '0;
    endtask

    initial begin
        int sent;
        int early;
        int b;
        int b_before;
        logic [DW-1:0] s2val;

        idle_src();
        for (int i = 0; i < NS; i++) bus.data_from_src[i] = '0;
        bus.ready_from_dst    = 1'b1;
        bus1.enable_from_src  = '0;
        bus1.eop_from_src     = '0;
        bus1.data_from_src[0] = '0;
        bus1.ready_from_dst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_enable", longint'(bus.enable_to_dst), 0);
        chk("reset_ready", longint'(bus.ready_to_src), 0);

        // Round-robin fairness: all sources request every cycle
        reset_n = 1'b1;
        bus.enable_from_src = '1;
        bus.eop_from_src    = '1;
        for (int i = 0; i < NS; i++) bus.data_from_src[i] = DW'(32'h100 + i);
        acc_q.delete(); idx_q.delete();
        step();
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_continuous", longint'(bus.enable_to_dst), 1);
        end
        chk("rr_count", idx_q.size(), 8);
        for (int i = 0; i < 8 && i < idx_q.size(); i++) chk("rr_order", idx_q[i], i % 4);

        // Back-pressure: source 2 streams A0..A7, destination ready 1,0,0,...
        idle_src();
        repeat (2) step();
        acc_q.delete(); idx_q.delete();
        s2val = 32'hA0;
        sent  = 0;
        bus.enable_from_src[2] = 1'b1;
        bus.eop_from_src[2]    = 1'b1;
        bus.data_from_src[2]   = s2val;
        for (int c = 0; c < 60 && sent < 8; c++) begin
            bus.ready_from_dst = (c % 3 == 0);
            step();
            if (last_grant == 2) begin
                sent++;
                s2val = s2val + 1;
                bus.data_from_src[2] = s2val;
                if (sent == 8) bus.enable_from_src[2] = 1'b0;
            end
        end
        chk("bp_sent", sent, 8);
        bus.ready_from_dst = 1'b1;
        repeat (3) step();
        chk("bp_count", acc_q.size(), 8);
        for (int i = 0; i < 8 && i < acc_q.size(); i++) chk("bp_data", longint'(acc_q[i]), 32'hA0 + i);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            bus.enable_from_src = NS'($urandom);
            bus.eop_from_src    = NS'($urandom);
            for (int i = 0; i < NS; i++) bus.data_from_src[i] = $urandom;
            bus.ready_from_dst  = ($urandom_range(0, 3) != 0);
            reset_n             = ($urandom_range(0, 63) != 0);
            step();
        end
        reset_n = 1'b1;
        bus.ready_from_dst = 1'b1;
        idle_src();
        repeat (3) step();

`ifdef OFS_PLAT_PRIM_ARB_PKT_LOCK_EN
        // Packet lock: source 1 three-beat packet against a busy source 0
        reset_n = 1'b0; step(); reset_n = 1'b1;
        bus.enable_from_src = 4'b0001;
        bus.eop_from_src    = 4'b0001;
        acc_q.delete(); idx_q.delete();
        step();
        b = 0; early = 0;
        bus.enable_from_src = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            bus.eop_from_src[1] = (b == 2);
            b_before = b;
            step();
            if (b_before < 3 && dut_ready_last[0]) early++;
            if (last_grant == 1) b++;
            if (b == 3) bus.enable_from_src[1] = 1'b0;
        end
        chk("lock_src0_early", early, 0);
        chk("lock_count_ok", longint'(idx_q.size() >= 5), 1);
        if (idx_q.size() >= 5) begin
            chk("lock_seq0", idx_q[0], 0);
            chk("lock_seq1", idx_q[1], 1);
            chk("lock_seq2", idx_q[2], 1);
            chk("lock_seq3", idx_q[3], 1);
            chk("lock_seq4", idx_q[4], 0);
        end

        // Locked source stalls: nobody else may be granted
        idle_src();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        bus.enable_from_src = 4'b1000;
        step();
        bus.enable_from_src = 4'b0111;
        bus.eop_from_src    = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_ready", longint'(dut_ready_last), 0);
        end
        chk("stall_drained", longint'(bus.enable_to_dst), 0);
        bus.enable_from_src = 4'b1111;
        step();
        chk("stall_resume", longint'(dut_ready_last), 4'b1000);

        // Start a locked packet from source 2 for the reset check below
        bus.enable_from_src = 4'b0100;
        bus.eop_from_src    = 4'b0000;
        step();
        step();
`else
        bus.enable_from_src = 4'b0100;
        bus.eop_from_src    = 4'b0000;
        step();
        step();
`endif

        // Reset mid-transfer: ready forced low, pointer back to 0 afterwards
        bus.enable_from_src = 4'b0101;
        reset_n = 1'b0;
        step();
        chk("midrst_ready", longint'(dut_ready_last), 0);
        chk("midrst_enable", longint'(bus.enable_to_dst), 0);
        reset_n = 1'b1;
        step();
        chk("post_rst_grant", longint'(dut_ready_last), 4'b0001);
        idle_src();
        repeat (2) step();

        // Single-source build behaves as a bubble-collapsing register
        bus1.enable_from_src  = 1'b1;
        bus1.eop_from_src     = 1'b1;
        bus1.data_from_src[0] = 32'h5;
        #1;
        chk("n1_ready", longint'(bus1.ready_to_src), 1);
        step();
        bus1.enable_from_src = 1'b0;
        chk("n1_enable", longint'(bus1.enable_to_dst), 1);
        chk("n1_data", longint'(bus1.data_to_dst), 5);
        chk("n1_idx", longint'(bus1.src_idx_to_dst), 0);
        step();
        chk("n1_drain", longint'(bus1.enable_to_dst), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ofs_plat_prim_ready_enable_arb.md
# ofs_plat_prim_ready_enable_arb

Round-robin arbiter that shares one ready/enable pipeline stage among N_SOURCES requesters. Each source presents a ready/enable channel. The block picks one source per transfer and registers the winning beat into a single output stage toward one destination. It sits wherever several ready/enable producers feed one shared channel, for example several engines feeding one host request port. Optionally, grants lock for the length of a multi-beat packet.

## Interface
- N_SOURCES, default 4: number of requesting sources, ≥1.
- N_DATA_BITS, default 32: payload width per beat.

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- enable_from_src  in  N_SOURCES  per-source beat valid
- data_from_src  in  N_SOURCES×N_DATA_BITS  per-source payload, unpacked array [N_SOURCES]
- eop_from_src  in  N_SOURCES  per-source last beat of packet
- ready_to_src  out  N_SOURCES  per-source accept; one-hot or zero
- enable_to_dst  out  1  output beat valid
- data_to_dst  out  N_DATA_BITS  output payload
- eop_to_dst  out  1  output last beat
- src_idx_to_dst  out  IDX_W  index of the source that produced the beat; IDX_W = max(1, $clog2(N_SOURCES))
- ready_from_dst  in  1  destination accept

## Operation
- Output stage can load when `out_free = !enable_to_dst || ready_from_dst`.
- Grant selection is combinational from `enable_from_src`, priority pointer `rr_ptr`, and lock state. Unlocked: the first requesting source at or after `rr_ptr`, searching upward modulo N_SOURCES. Locked: `lock_idx` only.
- `ready_to_src[g] = out_free && enable_from_src[g]` for the granted source g. All other bits are 0. No bit is ever set for a non-requesting source.
- Transfer from source g happens when `ready_to_src[g]`. On transfer the output stage loads data, eop and `src_idx = g`, and `enable_to_dst` becomes 1.
- When `out_free` is true and no transfer occurs, `enable_to_dst` becomes 0.
- Pointer update on transfer: when the beat ends arbitration, `rr_ptr <= (g+1) mod N_SOURCES`. Otherwise `rr_ptr` holds.
- Lock state (macro enabled): on a transfer with eop=0, `locked <= 1` and `lock_idx <= g`. On a transfer with eop=1, `locked <= 0`.
- While locked and the locked source deasserts enable, no other source is granted and the output stage drains to empty.
- Reset mid-packet discards the lock and any beat held in the output stage. Sources must restart their packets.
- Sources must not make enable depend on ready. The destination may drop ready at any time; the held beat stays stable until accepted.
- With N_SOURCES=1 the block degenerates to a bubble-collapsing register: src_idx is always 0 and the pointer is constant 0.

## Timing
- Latency is 1 cycle, source transfer to `enable_to_dst`. Throughput is 1 beat/cycle with ready_from_dst held at 1.
- `ready_to_src` is combinational from `ready_from_dst`, `enable_to_dst`, `enable_from_src`, `rr_ptr` and lock state. There is no combinational path from `data_from_src`.
- During reset (reset_n=0):
  - `ready_to_src` is forced to 0.
  - `enable_to_dst <= 0`, `rr_ptr <= 0`, `locked <= 0`, `lock_idx <= 0`.
  - `data_to_dst`, `eop_to_dst` and `src_idx_to_dst` are not reset; they are don't-care while `enable_to_dst` is 0.
- First grant is possible in the first cycle with reset_n=1.

## Configuration
- OFS_PLAT_PRIM_ARB_PKT_LOCK_EN defined:
  - The grant is held from a packet's first beat through its eop beat.
  - `rr_ptr` advances only on eop transfers.
- Not defined:
  - Arbitration is per beat and `rr_ptr` advances on every transfer.
  - eop is passed through unchanged but does not affect arbitration.
  - Lock registers are not instantiated.

## Structure
- Package `ofs_plat_prim_arb_pkg`:
  - function `idx_width(n)` returning max(1, $clog2(n)).
  - Typedef pattern for the source index. Modules declare a local `t_src_idx` using idx_width.
- Sub-module `ofs_plat_prim_rr_arb`:
  - Purely combinational.
  - Inputs: request vector, priority pointer. Outputs: one-hot grant, grant index, any-grant.
  - Reusable by other arbiters in the library.
- Top module `ofs_plat_prim_ready_enable_arb` holds:
  - the output register stage;
  - the pointer and lock registers;
  - ready generation.

## Test plan
- **Round-robin fairness:** N=4, lock off, all four enables held at 1, ready_from_dst=1 → `src_idx_to_dst` sequence 0,1,2,3,0,… with one beat per cycle and `enable_to_dst` continuously 1 after cycle 1.
- **Back-pressure:** single source 2 streams data 0xA0..0xA7, ready_from_dst toggled 1,0,0,1,… → every value appears exactly once, in order, and `data_to_dst` is stable while ready_from_dst=0.
- **Packet lock:** lock on, source 1 sends 3-beat packet (eop on beat 3) while source 0 requests continuously → output src_idx 1,1,1,0, and `ready_to_src[0]` stays 0 until source 1's eop transfers.
- **Locked-source stall:** lock on, source 3 sends beat 1 (eop=0), then deasserts enable for 5 cycles while sources 0–2 request → no grants for 5 cycles, `enable_to_dst` drops to 0, then source 3 resumes with beat 2.
- **Reset mid-packet:** reset_n pulsed low for 1 cycle during a locked packet from source 2 → `enable_to_dst`=0 and `ready_to_src`=0 during reset; next cycle source 0 requesting is granted (`rr_ptr`=0).
- **Degenerate width:** N=1, data=0x5 with enable → one cycle later `enable_to_dst`=1, data=0x5, src_idx=0.
